// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access legality check.
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_t;

  // Misalignment or an encoding that has no RV32I load/store meaning.
  function automatic logic access_fault(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic f;
    f = 1'b0;
    if (write) begin
      if (funct3 > F3_W) f = 1'b1;
    end else if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
      f = 1'b1;
    end
    if ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) f = 1'b1;
    if (funct3 == F3_W && addr_lo != 2'b00) f = 1'b1;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// Lane handling: load extract/extend and sub-word store merge into a
// word read back from memory.
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o = rword_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_data_o = {24'h0, w_byte};
      F3_H:    load_data_o = {{16{w_half[15]}}, w_half};
      F3_HU:   load_data_o = {16'h0, w_half};
      default: load_data_o = rword_i;
    endcase
  end

  always_comb begin
    merged_o = rword_i;
    case (funct3_i)
      F3_B:    merged_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H:    merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i;
      default: merged_o = rword_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-wide memory without byte enables;
// sub-word stores are done as read-modify-write.
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] byte_address,
  output logic [XLEN-1:0] write_data,
  output logic            MemWrite,
  output logic            MemRead,
  input  logic [XLEN-1:0] output_data
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            write_q, write_d;
  logic            fault_q, fault_d;

  logic [31:0]     w_load_data;
  logic [31:0]     w_merged;
  logic            w_fault;

  lsu_align u_align (
    .funct3_i    (f3_q),
    .addr_lo_i   (addr_q[1:0]),
    .rword_i     (output_data),
    .wdata_i     (wdata_q[15:0]),
    .load_data_o (w_load_data),
    .merged_o    (w_merged)
  );

  assign w_fault = access_fault(req_write, req_funct3, req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    write_d = write_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          write_d = req_write;
          fault_d = w_fault;
          rdata_d = '0;
          if (w_fault)                               state_d = ST_RESP;
          else if (req_write && req_funct3 == F3_W)  state_d = ST_WR;
          else                                       state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        // output_data is the word fetched by the previous cycle's MemRead.
        if (write_q) begin
          wdata_d = w_merged;
          state_d = ST_WR;
        end else begin
          rdata_d = w_load_data;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      write_q <= write_d;
      fault_q <= fault_d;
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  assign req_ready    = rst && (state_q == ST_IDLE);
  assign MemRead      = (state_q == ST_RD);
  assign MemWrite     = (state_q == ST_WR);
  assign byte_address = (MemRead || MemWrite) ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign write_data   = MemWrite ? wdata_q : '0;
  assign resp_valid   = (state_q == ST_RESP);
  assign resp_fault   = resp_valid && fault_q;
  assign resp_rdata   = resp_valid ? rdata_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a behavioural word memory.
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] byte_address;
  logic [31:0] write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] output_data;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .byte_address (byte_address),
    .write_data   (write_data),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .output_data  (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: writes on MemWrite, registered read data one cycle after MemRead.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (MemWrite) mem[byte_address[7:2]] <= write_data;
    if (MemRead)  output_data <= mem[byte_address[7:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_f;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd, input logic f,
                              input int lat, input int nrd, input int nwr);
    vec_t v;
    v.w = w; v.f3 = f3; v.a = a; v.d = d; v.exp_rd = rd; v.exp_f = f;
    v.exp_lat = lat; v.exp_nrd = nrd; v.exp_nwr = nwr;
    return v;
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic flt, output int nrd, output int nwr);
    wait_ready();
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 32'hx; flt = 1'bx; nrd = 0; nwr = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check("strobe_excl", {31'h0, MemRead & MemWrite}, 32'h0);
      if (MemRead)  nrd++;
      if (MemWrite) nwr++;
      if (MemRead || MemWrite) check("byte_address", byte_address, {a[31:2], 2'b00});
      if (resp_valid) begin
        lat = n; rd = resp_rdata; flt = resp_fault;
        break;
      end
    end
  endtask

  vec_t vecs[20];
  int   nvec;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nrd, nwr, m;
    logic [31:0] rd;
    logic flt;

    nvec = 0;
    vecs[nvec++] = mk(1, 3'b010, 32'h10, 32'h8899AABB, 32'h0,        0, 2, 0, 1); // SW
    vecs[nvec++] = mk(0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 0, 3, 1, 0); // LW
    vecs[nvec++] = mk(0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF88, 0, 3, 1, 0); // LB
    vecs[nvec++] = mk(0, 3'b100, 32'h13, 32'h0,        32'h00000088, 0, 3, 1, 0); // LBU
    vecs[nvec++] = mk(0, 3'b001, 32'h10, 32'h0,        32'hFFFFAABB, 0, 3, 1, 0); // LH
    vecs[nvec++] = mk(0, 3'b101, 32'h12, 32'h0,        32'h00008899, 0, 3, 1, 0); // LHU
    vecs[nvec++] = mk(1, 3'b000, 32'h11, 32'h123456CC, 32'h0,        0, 4, 1, 1); // SB
    vecs[nvec++] = mk(0, 3'b010, 32'h10, 32'h0,        32'h8899CCBB, 0, 3, 1, 0); // LW
    vecs[nvec++] = mk(1, 3'b001, 32'h12, 32'h00001234, 32'h0,        0, 4, 1, 1); // SH
    vecs[nvec++] = mk(0, 3'b010, 32'h10, 32'h0,        32'h1234CCBB, 0, 3, 1, 0); // LW
    vecs[nvec++] = mk(0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFBB, 0, 3, 1, 0); // LB
    vecs[nvec++] = mk(0, 3'b100, 32'h11, 32'h0,        32'h000000CC, 0, 3, 1, 0); // LBU
    vecs[nvec++] = mk(0, 3'b000, 32'h12, 32'h0,        32'h00000034, 0, 3, 1, 0); // LB
    vecs[nvec++] = mk(0, 3'b101, 32'h10, 32'h0,        32'h0000CCBB, 0, 3, 1, 0); // LHU
    vecs[nvec++] = mk(0, 3'b010, 32'h12, 32'h0,        32'h0,        1, 1, 0, 0); // LW misaligned
    vecs[nvec++] = mk(1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0,        1, 1, 0, 0); // SH misaligned
    vecs[nvec++] = mk(0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 1, 0, 0); // load f3=011
    vecs[nvec++] = mk(1, 3'b100, 32'h10, 32'h0,        32'h0,        1, 1, 0, 0); // store f3=100
    vecs[nvec++] = mk(0, 3'b101, 32'h11, 32'h0,        32'h0,        1, 1, 0, 0); // LHU misaligned
    vecs[nvec++] = mk(1, 3'b010, 32'h14, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1); // SW

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_req_ready",  {31'h0, req_ready},  32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_strobes",    {30'h0, MemRead, MemWrite}, 32'h0);
    check("rst_byte_addr",  byte_address, 32'h0);
    check("rst_write_data", write_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < nvec; i++) begin
      run_req(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].d, lat, rd, flt, nrd, nwr);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_fault", i), {31'h0, flt}, {31'h0, vecs[i].exp_f});
      check($sformatf("v%0d_memread_n", i), nrd, vecs[i].exp_nrd);
      check($sformatf("v%0d_memwrite_n", i), nwr, vecs[i].exp_nwr);
    end

    // Reset asserted during the WR cycle of an SB must abort the store.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'hEE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    m = 0;
    while (!MemWrite && m < 6) begin
      @(negedge clk);
      m++;
    end
    check("abort_wr_cycle", m, 3);
    rst = 1'b0;
    #1;
    check("abort_memwrite", {31'h0, MemWrite}, 32'h0);
    check("abort_req_ready", {31'h0, req_ready}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    rst = 1'b1;
    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt, nrd, nwr);
    check("abort_lw_rdata", rd, 32'h1234CCBB);
    check("abort_lw_latency", lat, 3);

    // Back-to-back: req_valid held across two LWs.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1 req_addr = 32'h14;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_low_c%0d", n), {31'h0, req_ready}, 32'h0);
    end
    check("b2b_resp1_valid", {31'h0, resp_valid}, 32'h1);
    check("b2b_resp1_rdata", resp_rdata, 32'h1234CCBB);
    @(negedge clk);
    check("b2b_ready_after_resp", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 32'h0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n; rd = resp_rdata;
        break;
      end
    end
    check("b2b_resp2_latency", lat, 3);
    check("b2b_resp2_rdata", rd, 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
